// File: rtl/avg_pkg.sv
// Shared state encoding and accumulator width helper for the averaging sequencer.
package avg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wide enough to hold maxcnt full-scale samples without overflow.
  function automatic int acc_width(input int datawidth, input int maxcnt);
    return datawidth + $clog2(maxcnt);
  endfunction

endpackage

// File: rtl/avg_seq_dp.sv
// Time-shared averaging datapath: one adder into the accumulator, one divider into avg.
module avg_seq_dp
  import avg_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int MAXCNT    = 8,
  parameter int ACCW      = acc_width(DATAWIDTH, MAXCNT)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 acc_clr,
  input  logic                 acc_en,
  input  logic                 avg_ld,
  input  logic                 avg_clr,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [DATAWIDTH-1:0] num_q,
  output logic [DATAWIDTH-1:0] avg
);

  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] sum;
  logic [ACCW-1:0] quo;

  always_comb begin
    sum = acc + ACCW'(in_data);
    quo = acc / ACCW'(num_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc <= '0;
      avg <= '0;
    end else begin
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= sum;
      // Quotient never exceeds the largest sample, so truncation is exact.
      if (avg_clr)     avg <= '0;
      else if (avg_ld) avg <= DATAWIDTH'(quo);
    end
  end

endmodule

// File: rtl/avg_seq_ctrl.sv
// Averaging sequencer: accepts num samples, accumulates serially, divides once, holds avg until taken.
// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting samples until num have arrived
// DIVIDE | one cycle, quotient registered into avg
// DONE   | avg/err presented, waiting for avg_ready
module avg_seq_ctrl
  import avg_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int MAXCNT    = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] num,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] avg,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int ACCW = acc_width(DATAWIDTH, MAXCNT);
  localparam int CNTW = $clog2(MAXCNT + 1);

  state_t                 state, state_nxt;
  logic [CNTW-1:0]        cnt;
  logic [CNTW-1:0]        cnt_inc;
  logic [DATAWIDTH-1:0]   num_q;
  logic                   num_ok;
  logic                   num_ld, cnt_clr, err_set, err_clr;
  logic                   acc_clr, acc_en, avg_ld, avg_clr;

  assign cnt_inc   = cnt + CNTW'(1);
  assign num_ok    = (num != '0) && (num <= DATAWIDTH'(MAXCNT));
  assign in_ready  = (state == ACCUM);
  assign avg_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      num_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)     cnt <= '0;
      else if (acc_en) cnt <= cnt_inc;
      if (num_ld) num_q <= num;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    num_ld    = 1'b0;
    cnt_clr   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    avg_ld    = 1'b0;
    avg_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_ok) begin
            num_ld    = 1'b1;
            cnt_clr   = 1'b1;
            acc_clr   = 1'b1;
            err_clr   = 1'b1;
            state_nxt = ACCUM;
          end else begin
            avg_clr   = 1'b1;
            err_set   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_en = 1'b1;
          if (DATAWIDTH'(cnt_inc) == num_q) state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        avg_ld    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (avg_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  avg_seq_dp #(
    .DATAWIDTH(DATAWIDTH),
    .MAXCNT   (MAXCNT),
    .ACCW     (ACCW)
  ) u_dp (
    .Clk    (Clk),
    .Rst    (Rst),
    .acc_clr(acc_clr),
    .acc_en (acc_en),
    .avg_ld (avg_ld),
    .avg_clr(avg_clr),
    .in_data(in_data),
    .num_q  (num_q),
    .avg    (avg)
  );

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Self-checking bench for avg_seq_ctrl: directed scenarios plus randomized runs against an arithmetic model.
module tb_avg_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [15:0] num;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] avg;
  logic        avg_valid;
  logic        avg_ready;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] smp [0:7];

  always #5 Clk = ~Clk;

  avg_seq_ctrl #(.DATAWIDTH(16), .MAXCNT(8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .num      (num),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .avg      (avg),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .busy     (busy),
    .err      (err)
  );

  // Reference: truncated mean of the first n samples; invalid n gives avg 0 with err.
  function automatic logic [15:0] model_avg(input int n);
    longint sum;
    sum = 0;
    if (n < 1 || n > 8) return 16'd0;
    for (int i = 0; i < n; i++) sum += smp[i];
    return 16'(sum / n);
  endfunction

  // Drives one complete run (start, samples with random gaps, output handshake) and reports what it saw.
  task automatic do_run(input int n, input int max_gap, input int ready_delay, input bit start_in_done,
                        output logic [15:0] o_avg, output logic o_err, output int busy_cyc,
                        output int valid_cyc, output int ready_seen, output bit unstable,
                        output bit timed_out, output bit idle_after);
    int idx, gap, rcnt, cyc;
    bit done;
    logic [15:0] first_avg;
    o_avg = 'x; o_err = 'x; busy_cyc = 0; valid_cyc = 0; ready_seen = 0; unstable = 0;
    idx = 0; rcnt = 0; cyc = 0; done = 0; first_avg = '0;
    gap = $urandom_range(max_gap, 0);
    @(negedge Clk);
    start = 1'b1; num = 16'(n); avg_ready = 1'b0;
    in_valid = 1'($urandom_range(1, 0)); in_data = 16'($urandom);
    @(negedge Clk);
    start = 1'b0;
    while (!done && cyc < 2000) begin
      cyc++;
      if (busy) busy_cyc++;
      if (in_ready) ready_seen++;
      // Outside ACCUM in_valid is noise that must be ignored.
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 16'($urandom);
      if (avg_valid) begin
        if (valid_cyc == 0) begin
          first_avg = avg; o_avg = avg; o_err = err;
        end else if (avg !== first_avg || err !== o_err) begin
          unstable = 1'b1;
        end
        valid_cyc++;
        start = start_in_done;
        if (rcnt >= ready_delay) begin
          avg_ready = 1'b1; done = 1'b1;
        end else begin
          avg_ready = 1'b0; rcnt++;
        end
      end else if (in_ready) begin
        if (gap > 0 || idx >= n) begin
          in_valid = 1'b0;
          if (gap > 0) gap--;
        end else begin
          in_valid = 1'b1; in_data = smp[idx]; idx++;
          gap = $urandom_range(max_gap, 0);
        end
      end
      @(negedge Clk);
    end
    timed_out = !done;
    start = 1'b0; avg_ready = 1'b0; in_valid = 1'b0;
    idle_after = !busy && !avg_valid;
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 0; num = 0; in_valid = 0; in_data = 0; avg_ready = 0;
    repeat (2) @(negedge Clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL reset_avg_valid got=%0b exp=0", avg_valid); end
    n_cmp++; if (avg !== 16'd0) begin n_err++; $display("FAIL reset_avg got=%0d exp=0", avg); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%0b exp=0", err); end
    Rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] a; logic e; int bc, vc, rs; bit un, to, ia;
    for (int i = 0; i < 8; i++) smp[i] = 16'(10 * (i + 1));
    do_run(8, 0, 0, 0, a, e, bc, vc, rs, un, to, ia);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout got=1 exp=0"); end
    n_cmp++; if (a !== 16'd45) begin n_err++; $display("FAIL basic_avg got=%0d exp=45", a); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL basic_err got=%0b exp=0", e); end
    n_cmp++; if (vc != 1) begin n_err++; $display("FAIL basic_valid_cycles got=%0d exp=1", vc); end
    // 8 ACCUM + DIVIDE + DONE; with the start cycle the run spans 11 cycles.
    n_cmp++; if (bc != 10) begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=10", bc); end
    n_cmp++; if (!ia) begin n_err++; $display("FAIL basic_idle_after got=0 exp=1"); end
  endtask

  task automatic test_gaps();
    logic [15:0] a; logic e; int bc, vc, rs; bit un, to, ia;
    int idx, cyc;
    smp[0] = 16'd1; smp[1] = 16'd1; smp[2] = 16'd2;
    @(negedge Clk); start = 1; num = 16'd3;
    @(negedge Clk); start = 0;
    idx = 0; cyc = 0;
    // Each sample preceded by two idle cycles.
    while (idx < 3 && cyc < 200) begin
      in_valid = 0; repeat (2) @(negedge Clk);
      in_valid = 1; in_data = smp[idx]; idx++;
      @(negedge Clk); in_valid = 0; cyc++;
    end
    cyc = 0;
    while (!avg_valid && cyc < 20) begin @(negedge Clk); cyc++; end
    a = avg; e = err;
    n_cmp++; if (avg_valid !== 1'b1) begin n_err++; $display("FAIL gaps_avg_valid got=%0b exp=1", avg_valid); end
    n_cmp++; if (a !== 16'd1) begin n_err++; $display("FAIL gaps_avg got=%0d exp=1", a); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL gaps_err got=%0b exp=0", e); end
    avg_ready = 1; @(negedge Clk); avg_ready = 0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gaps_idle got busy=%0b exp=0", busy); end
    bc = 0; vc = 0; rs = 0; un = 0; to = 0; ia = 0;
  endtask

  task automatic test_max();
    logic [15:0] a; logic e; int bc, vc, rs; bit un, to, ia;
    for (int i = 0; i < 8; i++) smp[i] = 16'hFFFF;
    do_run(8, 1, 0, 0, a, e, bc, vc, rs, un, to, ia);
    n_cmp++; if (to) begin n_err++; $display("FAIL max_timeout got=1 exp=0"); end
    n_cmp++; if (a !== 16'hFFFF) begin n_err++; $display("FAIL max_avg got=%h exp=ffff", a); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL max_err got=%0b exp=0", e); end
  endtask

  task automatic test_bad_num();
    logic [15:0] a; logic e; int bc, vc, rs; bit un, to, ia;
    int bad [2] = '{0, 9};
    foreach (bad[k]) begin
      do_run(bad[k], 0, 0, 0, a, e, bc, vc, rs, un, to, ia);
      n_cmp++; if (to) begin n_err++; $display("FAIL bad_num%0d_timeout got=1 exp=0", bad[k]); end
      n_cmp++; if (a !== 16'd0) begin n_err++; $display("FAIL bad_num%0d_avg got=%0d exp=0", bad[k], a); end
      n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL bad_num%0d_err got=%0b exp=1", bad[k], e); end
      n_cmp++; if (rs != 0) begin n_err++; $display("FAIL bad_num%0d_in_ready got=%0d cycles exp=0", bad[k], rs); end
      n_cmp++; if (bc != 1) begin n_err++; $display("FAIL bad_num%0d_busy got=%0d exp=1", bad[k], bc); end
      // Restore a nonzero avg so the next invalid run really has to clear it.
      smp[0] = 16'd77;
      do_run(1, 0, 0, 0, a, e, bc, vc, rs, un, to, ia);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a; logic e; int bc, vc, rs; bit un, to, ia;
    @(negedge Clk); start = 1; num = 16'd4;
    @(negedge Clk); start = 0;
    in_valid = 1; in_data = 16'd100; @(negedge Clk);
    in_data = 16'd200; @(negedge Clk);
    in_valid = 0; Rst = 1;
    @(negedge Clk); Rst = 0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready got=%0b exp=0", in_ready); end
    n_cmp++; if (avg_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_avg_valid got=%0b exp=0", avg_valid); end
    n_cmp++; if (avg !== 16'd0) begin n_err++; $display("FAIL rstmid_avg got=%0d exp=0", avg); end
    smp[0] = 16'd6; smp[1] = 16'd8;
    do_run(2, 0, 0, 0, a, e, bc, vc, rs, un, to, ia);
    n_cmp++; if (a !== 16'd7) begin n_err++; $display("FAIL rstmid_rerun_avg got=%0d exp=7", a); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL rstmid_rerun_err got=%0b exp=0", e); end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, exp_a; logic e; int bc, vc, rs; bit un, to, ia;
    for (int i = 0; i < 5; i++) smp[i] = 16'($urandom_range(65535, 1));
    exp_a = model_avg(5);
    do_run(5, 0, 5, 1, a, e, bc, vc, rs, un, to, ia);
    n_cmp++; if (a !== exp_a) begin n_err++; $display("FAIL bp_avg got=%0d exp=%0d", a, exp_a); end
    n_cmp++; if (vc != 6) begin n_err++; $display("FAIL bp_valid_cycles got=%0d exp=6", vc); end
    n_cmp++; if (un) begin n_err++; $display("FAIL bp_stable got=unstable exp=stable"); end
    n_cmp++; if (!ia) begin n_err++; $display("FAIL bp_idle_after got=busy exp=idle"); end
  endtask

  task automatic test_random();
    logic [15:0] a, exp_a; logic e, exp_e; int bc, vc, rs; bit un, to, ia;
    int n;
    for (int r = 0; r < 30; r++) begin
      n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(20, 9)) : int'($urandom_range(8, 1));
      if ($urandom_range(5, 0) == 0) n = 0;
      for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
      exp_a = model_avg(n);
      exp_e = (n < 1 || n > 8);
      do_run(n, 3, $urandom_range(3, 0), 1'($urandom_range(1, 0)), a, e, bc, vc, rs, un, to, ia);
      n_cmp++; if (to) begin n_err++; $display("FAIL rand%0d_timeout n=%0d", r, n); end
      n_cmp++; if (a !== exp_a) begin n_err++; $display("FAIL rand%0d_avg n=%0d got=%0d exp=%0d", r, n, a, exp_a); end
      n_cmp++; if (e !== exp_e) begin n_err++; $display("FAIL rand%0d_err n=%0d got=%0b exp=%0b", r, n, e, exp_e); end
      n_cmp++; if (un) begin n_err++; $display("FAIL rand%0d_stable got=unstable exp=stable", r); end
      n_cmp++; if (!ia) begin n_err++; $display("FAIL rand%0d_idle_after got=busy exp=idle", r); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_max();
    test_bad_num();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
